// File: rtl/sdram_frame_rd.sv
// rtl/sdram_frame_rd.sv - read-side SDRAM frame sequencer with show-ahead pixel FIFO
module sdram_frame_rd #(
    parameter int                ADDR_W      = 20,
    parameter int                DATA_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                FRAME_WORDS = 300,
    parameter int                BURST_LEN   = 8,
    parameter int                FIFO_AW     = 4
) (
    input  logic              S_CLK,
    input  logic              RST_N,
    input  logic              frame_start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    input  logic              rd_ack,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    input  logic              pix_req,
    output logic              busy,
    output logic              frame_done
);
    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int CNT_W  = $clog2(FRAME_WORDS + 1);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, CHECK, READ, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic               rd_en_d, busy_d, done_d;
    logic [ADDR_W-1:0]  addr_d;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               ack_ok, push, pop, full, empty;

    logic [31:0]        remaining, burst, free_after;
    logic               last_word, last_beat;

    assign empty     = (count == '0);
    assign full      = (count == (FIFO_AW+1)'(DEPTH));
    assign pix_valid = !empty;
    assign pix_data  = empty ? '0 : mem[rd_ptr];
    assign pop       = pix_req && !empty;
    assign ack_ok    = (state_q == READ) && rd_en && rd_ack;
    // A push into a full FIFO cannot happen while the CHECK gate holds; drop it if it ever does.
    assign push      = ack_ok && !full;

    always_ff @(posedge S_CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge S_CLK) begin
        if (push) mem[wr_ptr] <= rd_data;
    end

    // Free space counts the slot released by this cycle's pop so a burst can start a cycle earlier.
    assign remaining  = 32'(FRAME_WORDS) - 32'(word_cnt_q);
    assign burst      = (remaining < 32'(BURST_LEN)) ? remaining : 32'(BURST_LEN);
    assign free_after = 32'(DEPTH) - 32'(count) + 32'(pop);
    assign last_word  = (32'(word_cnt_q) == 32'(FRAME_WORDS - 1));
    assign last_beat  = (32'(beat_cnt_q) == 32'(BURST_LEN - 1)) || last_word;

    always_comb begin
        state_d    = state_q;
        rd_en_d    = rd_en;
        addr_d     = addr;
        busy_d     = busy;
        done_d     = 1'b0;
        word_cnt_d = word_cnt_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    addr_d     = BASE_ADDR;
                    word_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (free_after >= burst) begin
                    rd_en_d    = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = READ;
                end
            end
            READ: begin
                if (ack_ok) begin
                    addr_d     = addr + ADDR_W'(1);
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (last_beat) begin
                        rd_en_d = 1'b0;
                        if (last_word) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = CHECK;
                        end
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge S_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            rd_en      <= 1'b0;
            addr       <= BASE_ADDR;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            word_cnt_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_en      <= rd_en_d;
            addr       <= addr_d;
            busy       <= busy_d;
            frame_done <= done_d;
            word_cnt_q <= word_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
endmodule

// File: tb/tb_sdram_frame_rd.sv
// tb/tb_sdram_frame_rd.sv - randomized self-checking bench for sdram_frame_rd
module tb_sdram_frame_rd;
    localparam int FRAME = 20;
    localparam int BURST = 8;
    localparam int DEPTH = 16;

    logic        S_CLK, RST_N;
    logic        frame_start, rd_ack, pix_req;
    logic [15:0] rd_data;
    logic        rd_en, pix_valid, busy, frame_done;
    logic [19:0] addr;
    logic [15:0] pix_data;

    logic        w_frame_start, w_rd_ack, w_pix_req;
    logic [15:0] w_rd_data;
    logic        w_rd_en, w_pix_valid, w_busy, w_frame_done;
    logic [19:0] w_addr;
    logic [15:0] w_pix_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] q[$];
    int          m_words, m_burst, win_cnt, done_seen;
    logic [19:0] m_addr;
    bit          m_busy, m_done;
    int          bursts[$];

    sdram_frame_rd #(.ADDR_W(20), .DATA_W(16), .BASE_ADDR(20'h0), .FRAME_WORDS(FRAME),
                     .BURST_LEN(BURST), .FIFO_AW(4)) u_dut (
        .S_CLK(S_CLK), .RST_N(RST_N), .frame_start(frame_start), .rd_en(rd_en), .addr(addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_req(pix_req), .busy(busy), .frame_done(frame_done));

    sdram_frame_rd #(.ADDR_W(20), .DATA_W(16), .BASE_ADDR(20'hFFFFE), .FRAME_WORDS(4),
                     .BURST_LEN(8), .FIFO_AW(4)) u_wrap (
        .S_CLK(S_CLK), .RST_N(RST_N), .frame_start(w_frame_start), .rd_en(w_rd_en), .addr(w_addr),
        .rd_ack(w_rd_ack), .rd_data(w_rd_data), .pix_valid(w_pix_valid), .pix_data(w_pix_data),
        .pix_req(w_pix_req), .busy(w_busy), .frame_done(w_frame_done));

    initial S_CLK = 1'b0;
    always #5 S_CLK = ~S_CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_words = 0;
        m_addr  = 20'h0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
        win_cnt = 0;
        m_burst = 0;
    endtask

    // One clock: check outputs against the model, drive inputs, advance the model past the edge.
    task automatic step(input bit ack, input bit req, input bit fs);
        bit          en_pre, busy_pre, push, pop;
        logic [15:0] d;
        en_pre   = rd_en;
        busy_pre = m_busy;
        check_eq("pix_valid", pix_valid, q.size() != 0);
        check_eq("pix_data", pix_data, (q.size() != 0) ? 32'(q[0]) : 32'h0);
        check_eq("busy", busy, m_busy);
        check_eq("frame_done", frame_done, m_done);
        if (rd_en) begin
            check_eq("addr", addr, m_addr);
            check_eq("rd_en_busy", m_busy, 1);
        end
        d           = 16'($urandom);
        rd_ack      = ack;
        rd_data     = d;
        pix_req     = req;
        frame_start = fs;
        push = en_pre && ack;
        pop  = req && (q.size() != 0);
        @(posedge S_CLK);
        #1;
        rd_ack      = 1'b0;
        frame_start = 1'b0;
        pix_req     = 1'b0;
        if (frame_done) done_seen++;
        if (m_done) m_busy = 1'b0;
        m_done = 1'b0;
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(d);
            m_words++;
            m_addr++;
            win_cnt++;
            if (m_words == FRAME) m_done = 1'b1;
        end
        if (fs && !busy_pre) begin
            m_busy  = 1'b1;
            m_words = 0;
            m_addr  = 20'h0;
        end
        if (rd_en && !en_pre) begin
            m_burst = (FRAME - m_words < BURST) ? FRAME - m_words : BURST;
            win_cnt = 0;
            check_eq("gate_free", (DEPTH - q.size()) >= m_burst, 1);
        end
        if (!rd_en && en_pre) begin
            check_eq("burst_len", win_cnt, m_burst);
            bursts.push_back(win_cnt);
        end
    endtask

    task automatic run_frame(input int ack_pct, input int req_pct, input bit noise, input int budget);
        int c;
        bit a, r, f;
        bursts.delete();
        done_seen = 0;
        step(0, 0, 1);
        c = 0;
        while ((m_busy || q.size() != 0) && c < budget) begin
            a = (rd_en || noise) && ($urandom_range(99) < ack_pct);
            r = $urandom_range(99) < req_pct;
            f = noise && m_busy && ($urandom_range(7) == 0);
            step(a, r, f);
            c++;
        end
        check_eq("frame_timeout", (m_busy || q.size() != 0), 0);
        check_eq("done_pulses", done_seen, 1);
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && (m_busy || q.size() != 0); c++) step(rd_en, 1, 0);
        check_eq("drain_timeout", (m_busy || q.size() != 0), 0);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_rd_en", rd_en, 0);
        check_eq("rst_addr", addr, 20'h0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_pix_valid", pix_valid, 0);
        check_eq("rst_pix_data", pix_data, 0);
    endtask

    logic [19:0] w_addrs[$];
    logic [19:0] exp_a[4];
    logic [15:0] exp_p[4];
    int          w_idx, w_done;

    initial begin
        RST_N = 1'b0;
        frame_start = 1'b0; rd_ack = 1'b0; pix_req = 1'b0; rd_data = '0;
        w_frame_start = 1'b0; w_rd_ack = 1'b0; w_pix_req = 1'b0; w_rd_data = '0;
        model_reset();
        #12;
        check_reset_outputs();
        @(posedge S_CLK); #1;
        RST_N = 1'b1;

        // Basic frame: acks every cycle, consumer always ready -> windows 8, 8, 4.
        run_frame(100, 100, 0, 400);
        check_eq("basic_nbursts", bursts.size(), 3);
        check_eq("basic_burst0", bursts[0], 8);
        check_eq("basic_burst1", bursts[1], 8);
        check_eq("basic_burst2", bursts[2], 4);

        // Backpressure: no pops until the FIFO fills.
        bursts.delete();
        done_seen = 0;
        step(0, 0, 1);
        for (int c = 0; c < 60; c++) step(rd_en, 0, 0);
        check_eq("bp_words", m_words, 16);
        check_eq("bp_rd_en_low", rd_en, 0);
        check_eq("bp_valid", pix_valid, 1);
        for (int c = 0; c < 8; c++) step(rd_en, 1, 0);
        for (int c = 0; c < 20; c++) step(rd_en, 0, 0);
        check_eq("bp_words_after", m_words, 20);
        check_eq("bp_nbursts", bursts.size(), 3);
        check_eq("bp_last_burst", bursts[bursts.size()-1], 4);
        drain(200);
        check_eq("bp_done_pulses", done_seen, 1);

        // Simultaneous push and pop with five words buffered.
        bursts.delete();
        done_seen = 0;
        step(0, 0, 1);
        for (int c = 0; c < 40 && m_words < 5; c++) step(rd_en, 0, 0);
        check_eq("pp_fill", m_words, 5);
        check_eq("pp_rd_en", rd_en, 1);
        for (int c = 0; c < 3; c++) begin
            step(1, 1, 0);
            check_eq("pp_valid", pix_valid, 1);
        end
        drain(200);
        check_eq("pp_done_pulses", done_seen, 1);

        // Random traffic with spurious acks and frame_start pulses.
        for (int f = 0; f < 6; f++) run_frame(30 + 10 * f, 20 + 12 * f, 1, 3000);

        // Reset mid-burst at word 11.
        step(0, 0, 1);
        for (int c = 0; c < 80 && !(m_words == 11 && rd_en); c++) step(rd_en, 1'($urandom_range(1)), 0);
        check_eq("rst_reach_words", m_words, 11);
        check_eq("rst_reach_rd_en", rd_en, 1);
        RST_N = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge S_CLK); #1;
        RST_N = 1'b1;
        run_frame(100, 100, 0, 400);
        check_eq("restart_nbursts", bursts.size(), 3);
        check_eq("restart_burst0", bursts[0], 8);

        // Address wrap on the second instance.
        exp_a = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
        exp_p = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        w_idx = 0;
        w_done = 0;
        w_frame_start = 1'b1;
        @(posedge S_CLK); #1;
        w_frame_start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            w_rd_ack  = w_rd_en;
            w_rd_data = w_addr[15:0];
            if (w_rd_en) w_addrs.push_back(w_addr);
            w_pix_req = 1'b1;
            if (w_pix_valid) begin
                if (w_idx < 4) check_eq("wrap_pix", w_pix_data, exp_p[w_idx]);
                w_idx++;
            end
            @(posedge S_CLK); #1;
            if (w_frame_done) w_done++;
        end
        w_rd_ack = 1'b0;
        w_pix_req = 1'b0;
        check_eq("wrap_nwords", w_addrs.size(), 4);
        for (int i = 0; i < 4; i++) check_eq("wrap_addr", w_addrs[i], exp_a[i]);
        check_eq("wrap_done", w_done, 1);
        check_eq("wrap_pops", w_idx, 4);
        check_eq("wrap_busy", w_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
